// File: rtl/du_report_receiver_pkg.sv
// Shared constants and encodings for the debug-unit UART report receiver.
// Byte/word widths match the debug unit's transmit side.
package du_report_receiver_pkg;

  localparam int NB_BYTE = 8;
  localparam int NB_DATA = 32;

  localparam logic [1:0] FIELD_PC     = 2'd0;
  localparam logic [1:0] FIELD_CYCLES = 2'd1;
  localparam logic [1:0] FIELD_REG    = 2'd2;
  localparam logic [1:0] FIELD_MEM    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_CYCLES,
    ST_REGS,
    ST_MEM
  } state_t;

  // Field tag reported for a word completed while in the given state.
  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      ST_CYCLES: field_of = FIELD_CYCLES;
      ST_REGS:   field_of = FIELD_REG;
      ST_MEM:    field_of = FIELD_MEM;
      default:   field_of = FIELD_PC;
    endcase
  endfunction

endpackage

// File: rtl/du_word_assembler.sv
// Big-endian byte-to-word assembler: first byte of a word lands in the MSB.
// word_done/word_full are combinational on the strobe carrying the last byte.
module du_word_assembler
  import du_report_receiver_pkg::*;
#(
  parameter int NB_DATA = du_report_receiver_pkg::NB_DATA,
  parameter int NB_BYTE = du_report_receiver_pkg::NB_BYTE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [NB_BYTE-1:0] rx_byte,
  input  logic               rx_valid,
  output logic [NB_DATA-1:0] word_full,
  output logic               word_done
);

  // Only the first three bytes need storing; the fourth comes straight from rx_byte.
  logic [NB_DATA-NB_BYTE-1:0] shreg;
  logic [1:0]                 cnt;

  assign word_full = {shreg, rx_byte};
  assign word_done = rx_valid && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (rx_valid) begin
      shreg <= word_full[NB_DATA-NB_BYTE-1:0];
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/du_report_receiver.sv
// Host-side receiver for the debug-unit report stream: reassembles words,
// tags them with field/index, and aborts frames on an inter-byte gap timeout.
module du_report_receiver
  import du_report_receiver_pkg::*;
#(
  parameter int NB_DATA      = du_report_receiver_pkg::NB_DATA,
  parameter int NB_BYTE      = du_report_receiver_pkg::NB_BYTE,
  parameter int N_REGISTERS  = 32,
  parameter int N_MEM_WORDS  = 32,
  parameter int NB_INDEX     = 6,
  parameter int TIMEOUT_CLKS = 200000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_byte,
  input  logic                i_rx_valid,
  output logic [NB_DATA-1:0]  o_word,
  output logic                o_word_valid,
  output logic [1:0]          o_field,
  output logic [NB_INDEX-1:0] o_index,
  output logic                o_frame_done,
  output logic                o_timeout_err,
  output logic                o_busy
);

  localparam int GW = $clog2(TIMEOUT_CLKS + 1);

  state_t              state, state_nxt;
  logic [NB_INDEX-1:0] idx, idx_nxt;
  logic [GW-1:0]       gap, gap_nxt;
  logic                timeout, last_word;
  logic                word_done;
  logic [NB_DATA-1:0]  word_full;

  du_word_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_asm (
    .clk       (i_clock),
    .reset     (i_reset),
    .clear     (timeout),
    .rx_byte   (i_rx_byte),
    .rx_valid  (i_rx_valid),
    .word_full (word_full),
    .word_done (word_done)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    last_word = 1'b0;
    gap_nxt   = (state == ST_IDLE || i_rx_valid) ? '0 : gap + 1'b1;
    // A byte on the same cycle the gap would expire keeps the frame alive.
    timeout   = (state != ST_IDLE) && !i_rx_valid && (gap == GW'(TIMEOUT_CLKS - 1));
    case (state)
      ST_IDLE:   if (i_rx_valid) begin state_nxt = ST_PC; idx_nxt = '0; end
      ST_PC:     if (word_done) state_nxt = ST_CYCLES;
      ST_CYCLES: if (word_done) begin state_nxt = ST_REGS; idx_nxt = '0; end
      ST_REGS:
        if (word_done) begin
          if (idx == NB_INDEX'(N_REGISTERS - 1)) begin
            state_nxt = ST_MEM;
            idx_nxt   = '0;
          end else idx_nxt = idx + 1'b1;
        end
      ST_MEM:
        if (word_done) begin
          if (idx == NB_INDEX'(N_MEM_WORDS - 1)) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            last_word = 1'b1;
          end else idx_nxt = idx + 1'b1;
        end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      gap_nxt   = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      gap           <= '0;
      o_word        <= '0;
      o_word_valid  <= 1'b0;
      o_field       <= 2'd0;
      o_index       <= '0;
      o_frame_done  <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      gap           <= gap_nxt;
      o_word_valid  <= word_done;
      o_frame_done  <= last_word;
      o_timeout_err <= timeout;
      if (word_done) begin
        o_word  <= word_full;
        o_field <= field_of(state);
        o_index <= idx;
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_du_report_receiver.sv
// Directed + randomized bench for du_report_receiver, checked cycle by cycle
// against a byte-position model of the report frame.
module tb_du_report_receiver;

  localparam int NR    = 4;
  localparam int NM    = 2;
  localparam int T     = 100;
  localparam int WORDS = 2 + NR + NM;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_byte = '0;
  logic        i_rx_valid = 1'b0;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic [1:0]  o_field;
  logic [5:0]  o_index;
  logic        o_frame_done;
  logic        o_timeout_err;
  logic        o_busy;

  du_report_receiver #(
    .N_REGISTERS  (NR),
    .N_MEM_WORDS  (NM),
    .NB_INDEX     (6),
    .TIMEOUT_CLKS (T)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_rx_byte     (i_rx_byte),
    .i_rx_valid    (i_rx_valid),
    .o_word        (o_word),
    .o_word_valid  (o_word_valid),
    .o_field       (o_field),
    .o_index       (o_index),
    .o_frame_done  (o_frame_done),
    .o_timeout_err (o_timeout_err),
    .o_busy        (o_busy)
  );

  always #5 i_clock = ~i_clock;

  int tests = 0;
  int fails = 0;
  int fd_seen = 0;
  int to_seen = 0;

  // Model: byte position inside the frame and idle cycles since last byte.
  int          pos = 0;
  int          gap = 0;
  logic [31:0] acc = '0;
  logic [31:0] exp_word = '0;
  logic        exp_wv, exp_fd, exp_to, exp_busy;
  logic [1:0]  exp_field;
  logic [5:0]  exp_index;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic v, input logic [7:0] b);
    int w;
    exp_wv = 0; exp_fd = 0; exp_to = 0;
    if (i_reset) begin
      pos = 0; gap = 0; exp_word = '0;
    end else if (v) begin
      acc = {acc[23:0], b};
      pos++;
      gap = 0;
      if (pos % 4 == 0) begin
        w = pos / 4 - 1;
        exp_wv   = 1;
        exp_word = acc;
        if (w == 0)          begin exp_field = 2'd0; exp_index = 6'(0); end
        else if (w == 1)     begin exp_field = 2'd1; exp_index = 6'(0); end
        else if (w < 2 + NR) begin exp_field = 2'd2; exp_index = 6'(w - 2); end
        else                 begin exp_field = 2'd3; exp_index = 6'(w - 2 - NR); end
        if (w == WORDS - 1) begin exp_fd = 1; pos = 0; end
      end
    end else if (pos > 0) begin
      gap++;
      if (gap == T) begin exp_to = 1; pos = 0; gap = 0; end
    end
    exp_busy = (pos > 0);
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    i_rx_valid = v;
    i_rx_byte  = b;
    model(v, b);
    @(posedge i_clock);
    #1;
    chk("word_valid", 32'(o_word_valid), 32'(exp_wv));
    chk("frame_done", 32'(o_frame_done), 32'(exp_fd));
    chk("timeout_err", 32'(o_timeout_err), 32'(exp_to));
    chk("busy", 32'(o_busy), 32'(exp_busy));
    chk("word", o_word, exp_word);
    if (exp_wv) begin
      chk("field", 32'(o_field), 32'(exp_field));
      chk("index", 32'(o_index), 32'(exp_index));
    end
    if (o_frame_done) fd_seen++;
    if (o_timeout_err) to_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i*8 +: 8]);
  endtask

  task automatic send_bytes(input int n, input int gap_cycles);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 8'($urandom));
      idle(gap_cycles);
    end
  endtask

  task automatic send_fixed_frame(input logic [31:0] pc);
    send_word(pc);
    send_word(32'h44444444);
    for (int i = 0; i < NR; i++) send_word(32'hB0B0B0B0);
    for (int i = 0; i < NM; i++) send_word(32'h00110011);
  endtask

  task automatic send_rand_frame(input int max_gap);
    for (int i = 0; i < 4 * WORDS; i++) begin
      step(1'b1, 8'($urandom));
      idle($urandom_range(max_gap, 0));
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(1'b0, 8'h00);
    i_reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    do_reset();

    // Full fixed frame
    fd_seen = 0;
    send_fixed_frame(32'hAABBCCDD);
    idle(3);
    chk("full_frame_done_count", 32'(fd_seen), 32'd1);

    // Byte order 11,22,33,44 as PC
    send_word(32'h11223344);
    chk("byte_order_word", o_word, 32'h11223344);
    send_bytes(4 * WORDS - 4, 0);
    idle(2);

    // Timeout after 6 bytes
    to_seen = 0;
    send_bytes(6, 0);
    idle(T + 5);
    chk("timeout_pulses", 32'(to_seen), 32'd1);
    chk("timeout_busy", 32'(o_busy), 32'd0);
    fd_seen = 0;
    send_fixed_frame(32'h0BADF00D);
    idle(2);
    chk("post_timeout_frame", 32'(fd_seen), 32'd1);

    // Boundary: every byte arrives exactly T cycles after the previous
    to_seen = 0;
    fd_seen = 0;
    send_bytes(4 * WORDS, T - 1);
    chk("boundary_no_timeout", 32'(to_seen), 32'd0);
    chk("boundary_frame_done", 32'(fd_seen), 32'd1);

    // Reset mid-frame after 10 bytes
    send_bytes(10, 0);
    do_reset();
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_word", o_word, 32'd0);
    fd_seen = 0;
    send_fixed_frame(32'hCAFEBABE);
    idle(2);
    chk("post_reset_frame", 32'(fd_seen), 32'd1);

    // Back-to-back frames, zero gap
    fd_seen = 0;
    send_rand_frame(0);
    send_rand_frame(0);
    idle(2);
    chk("b2b_frames", 32'(fd_seen), 32'd2);

    // Randomized frames with small gaps, one truncated by timeout
    for (int f = 0; f < 4; f++) send_rand_frame(3);
    send_bytes($urandom_range(4 * WORDS - 1, 1), 0);
    idle(T + 2);
    send_rand_frame(2);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
